// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin system bus arbiter: FSM state
// encoding, well-known master indices and a width helper.
package bus_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } arbState_e;

  localparam int CAMERA_MASTER  = 0;
  localparam int CPU_MASTER     = 1;
  localparam int DMA_MASTER     = 2;
  localparam int DISPLAY_MASTER = 3;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Bus-side signals of the arbiter: request/grant lines, the shared
// transaction framing strobes and the bus error lines.
interface bus_arbiter_rr_if
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NR_OF_MASTERS = 4
);

  logic [NR_OF_MASTERS-1:0] requests;
  logic [NR_OF_MASTERS-1:0] grants;
  logic                     beginTransactionIn;
  logic                     endTransactionIn;
  logic                     busErrorIn;
  logic                     busErrorOut;
  logic [2:0]               activeMaster;
  logic                     busy;

  // The arbiter is the slave side; the masters (or a bench) drive the rest.
  modport slave (
    input  requests,
    input  beginTransactionIn,
    input  endTransactionIn,
    input  busErrorIn,
    output grants,
    output busErrorOut,
    output activeMaster,
    output busy
  );

  modport master (
    output requests,
    output beginTransactionIn,
    output endTransactionIn,
    output busErrorIn,
    input  grants,
    input  busErrorOut,
    input  activeMaster,
    input  busy
  );

endinterface

// File: rtl/bus_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first requesting master at or after the
// pointer, wrapping around past the highest index.
module rr_priority_pick
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NR_OF_MASTERS = 4,
  parameter int PTR_W         = clog2(NR_OF_MASTERS)
) (
  input  logic [NR_OF_MASTERS-1:0] requests,
  input  logic [PTR_W-1:0]         rrPointer,
  output logic [PTR_W-1:0]         pickIndex,
  output logic                     pickValid
);

  localparam logic [PTR_W:0] NR_EXT = (PTR_W+1)'(NR_OF_MASTERS);

  logic [NR_OF_MASTERS-1:0] rotated;
  logic [PTR_W-1:0]         offset;
  logic [PTR_W:0]           sum;

  // Rotating a doubled copy puts the pointer's master at bit 0.
  assign rotated = NR_OF_MASTERS'({requests, requests} >> rrPointer);

  always_comb begin
    offset = '0;
    for (int i = NR_OF_MASTERS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = PTR_W'(i);
      end
    end
  end

  assign sum       = {1'b0, rrPointer} + {1'b0, offset};
  assign pickIndex = (sum >= NR_EXT) ? PTR_W'(sum - NR_EXT) : sum[PTR_W-1:0];
  assign pickValid = |requests;

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner arbiter for the shared system bus: holds a one-hot grant
// through begin..end of a transaction and reclaims the bus if begin never comes.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NR_OF_MASTERS  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clock,
  input  logic            reset,
  bus_arbiter_rr_if.slave bus
);

  localparam int PTR_W   = clog2(NR_OF_MASTERS);
  localparam int TIMER_W = clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0]   LAST_MASTER = PTR_W'(NR_OF_MASTERS - 1);

  arbState_e                state_q, state_d;
  logic [NR_OF_MASTERS-1:0] grants_q, grants_d;
  logic [PTR_W-1:0]         activeMaster_q, activeMaster_d;
  logic [PTR_W-1:0]         rrPointer_q, rrPointer_d;
  logic [TIMER_W-1:0]       timer_q, timer_d;
  logic                     busErrorOut_q, busErrorOut_d;
  logic                     busy_q, busy_d;

  logic [PTR_W-1:0]         pickIndex;
  logic                     pickValid;
  logic                     unusedBusErrorIn;

  // A slave error never shortens ownership; the master still ends the burst.
  assign unusedBusErrorIn = bus.busErrorIn;

  rr_priority_pick #(
    .NR_OF_MASTERS (NR_OF_MASTERS),
    .PTR_W         (PTR_W)
  ) u_pick (
    .requests  (bus.requests),
    .rrPointer (rrPointer_q),
    .pickIndex (pickIndex),
    .pickValid (pickValid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      grants_q       <= '0;
      activeMaster_q <= '0;
      rrPointer_q    <= '0;
      timer_q        <= '0;
      busErrorOut_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      grants_q       <= grants_d;
      activeMaster_q <= activeMaster_d;
      rrPointer_q    <= rrPointer_d;
      timer_q        <= timer_d;
      busErrorOut_q  <= busErrorOut_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grants_d       = grants_q;
    activeMaster_d = activeMaster_q;
    rrPointer_d    = rrPointer_q;
    timer_d        = timer_q;
    busErrorOut_d  = 1'b0;
    busy_d         = busy_q;

    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d        = GRANT;
          grants_d       = NR_OF_MASTERS'(1) << pickIndex;
          activeMaster_d = pickIndex;
          timer_d        = TIMER_INIT;
          busy_d         = 1'b1;
        end
      end

      GRANT: begin
        // Begin wins over an expiring timer; end alone is not a transaction.
        if (bus.beginTransactionIn) begin
          if (bus.endTransactionIn) begin
            state_d  = RELEASE;
            grants_d = '0;
            busy_d   = 1'b0;
          end else begin
            state_d = ACTIVE;
          end
        end else if (timer_q == '0) begin
          state_d       = RELEASE;
          grants_d      = '0;
          busy_d        = 1'b0;
          busErrorOut_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      ACTIVE: begin
        if (bus.endTransactionIn) begin
          state_d  = RELEASE;
          grants_d = '0;
          busy_d   = 1'b0;
        end
      end

      RELEASE: begin
        state_d     = IDLE;
        rrPointer_d = (activeMaster_q == LAST_MASTER) ? '0 : activeMaster_q + 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.grants       = grants_q;
  assign bus.busErrorOut  = busErrorOut_q;
  assign bus.busy         = busy_q;
  assign bus.activeMaster = 3'(activeMaster_q);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed ownership scenarios followed by random
// transactions, checked against a round-robin reference kept in the bench.
module tb_bus_arbiter_rr;

  localparam int NR      = 4;
  localparam int TIMEOUT = 4;

  logic clock;
  logic reset;

  int assertionCount = 0;
  int failureCount   = 0;
  int ptrModel       = 0;
  logic [NR-1:0] reqDriven = '0;

  bus_arbiter_rr_if #(.NR_OF_MASTERS(NR)) bus ();

  bus_arbiter_rr #(
    .NR_OF_MASTERS  (NR),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertionCount++;
    if (observed !== expected) begin
      failureCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] req, input logic beginIn, input logic endIn, input logic errIn);
    reqDriven              = req;
    bus.requests           = req;
    bus.beginTransactionIn = beginIn;
    bus.endTransactionIn   = endIn;
    bus.busErrorIn         = errIn;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference rule: nearest requesting index at or after the pointer, wrapping.
  function automatic int expectedOwner(input logic [NR-1:0] req, input int ptr);
    int owner;
    owner = -1;
    for (int off = NR - 1; off >= 0; off--) begin
      if (req[(ptr + off) % NR]) owner = (ptr + off) % NR;
    end
    return owner;
  endfunction

  task automatic checkHeld(input string tag, input int owner);
    checkOutput({tag, ".grants"}, 32'(bus.grants), 32'(1) << owner);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, ".busErrorOut"}, 32'(bus.busErrorOut), 32'd0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".grants"}, 32'(bus.grants), 32'd0);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, ".busErrorOut"}, 32'(bus.busErrorOut), 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("reset.grants", 32'(bus.grants), 32'd0);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.busErrorOut", 32'(bus.busErrorOut), 32'd0);
    checkOutput("reset.activeMaster", 32'(bus.activeMaster), 32'd0);
    reset    = 1'b0;
    ptrModel = 0;
  endtask

  // Called at a negedge in IDLE with a non-zero request vector applied.
  task automatic awaitGrant(output int owner);
    owner = expectedOwner(reqDriven, ptrModel);
    tick();
    checkOutput("grant.grants", 32'(bus.grants), 32'(1) << owner);
    checkOutput("grant.activeMaster", 32'(bus.activeMaster), 32'(owner));
    checkOutput("grant.busy", 32'(bus.busy), 32'd1);
    checkOutput("grant.busErrorOut", 32'(bus.busErrorOut), 32'd0);
  endtask

  // mode 0: begin..end burst, mode 1: begin and end together, mode 2: no begin.
  task automatic finishTransaction(input int owner, input int mode, input int waitCycles,
                                   input int activeCycles, input bit errActive,
                                   input logic [NR-1:0] reqAfter, input logic [NR-1:0] nextReq);
    logic expectErr;
    expectErr = 1'b0;
    if (mode == 2) begin
      for (int k = 0; k < TIMEOUT; k++) begin
        applyStimulus(reqAfter, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        tick();
        if (k < TIMEOUT - 1) checkHeld("timeoutWait", owner);
      end
      expectErr = 1'b1;
    end else begin
      for (int k = 0; k < waitCycles; k++) begin
        applyStimulus(reqAfter, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        tick();
        checkHeld("grantWait", owner);
      end
      applyStimulus(reqAfter, 1'b1, (mode == 1), 1'b0);
      tick();
      if (mode == 0) begin
        checkHeld("begin", owner);
        for (int k = 0; k < activeCycles; k++) begin
          applyStimulus(reqAfter, 1'($urandom_range(0, 1)), 1'b0,
                        errActive ? 1'b1 : 1'($urandom_range(0, 1)));
          tick();
          checkHeld("active", owner);
        end
        applyStimulus(reqAfter, 1'b0, 1'b1, errActive);
        tick();
      end
    end
    checkOutput("release.grants", 32'(bus.grants), 32'd0);
    checkOutput("release.busy", 32'(bus.busy), 32'd0);
    checkOutput("release.busErrorOut", 32'(bus.busErrorOut), 32'(expectErr));
    ptrModel = (owner + 1) % NR;
    applyStimulus(nextReq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    tick();
    checkIdle("turnaround");
    applyStimulus(nextReq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    int owner;
    int mode;
    int roll;
    int idleCycles;
    logic [NR-1:0] nextReq;

    reset = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    doReset();

    // Single master: grant, begin one cycle later, end three cycles after that.
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    awaitGrant(owner);
    finishTransaction(owner, 0, 0, 2, 1'b0, 4'b0000, 4'b0000);

    // All masters requesting: order 0,1,2,3,0, then 1 alone, then wrap to 0.
    doReset();
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      awaitGrant(owner);
      finishTransaction(owner, 0, 0, 1, 1'b0, 4'b1111, (i == 4) ? 4'b0010 : 4'b1111);
    end
    awaitGrant(owner);
    finishTransaction(owner, 0, 1, 0, 1'b0, 4'b0000, 4'b0011);
    awaitGrant(owner);
    finishTransaction(owner, 1, 0, 0, 1'b0, 4'b0000, 4'b0100);

    // Watchdog on master 2, master 3 waiting behind it.
    awaitGrant(owner);
    finishTransaction(owner, 2, 0, 0, 1'b0, 4'b1000, 4'b1000);
    awaitGrant(owner);
    finishTransaction(owner, 0, 2, 1, 1'b0, 4'b0000, 4'b0001);

    // Slave error during the burst must not release the bus.
    awaitGrant(owner);
    finishTransaction(owner, 0, 1, 3, 1'b1, 4'b0000, 4'b0100);

    // Asynchronous reset in the middle of an active burst.
    awaitGrant(owner);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    checkHeld("preReset", owner);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncReset.grants", 32'(bus.grants), 32'd0);
    checkOutput("asyncReset.busy", 32'(bus.busy), 32'd0);
    checkOutput("asyncReset.activeMaster", 32'(bus.activeMaster), 32'd0);
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    ptrModel = 0;
    applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
    awaitGrant(owner);
    finishTransaction(owner, 0, 0, 1, 1'b0, 4'b1010, 4'b0000);

    // Random traffic against the reference.
    for (int e = 0; e < 150; e++) begin
      if (reqDriven == '0) begin
        idleCycles = $urandom_range(1, 3);
        for (int k = 0; k < idleCycles; k++) begin
          tick();
          checkIdle("idle");
        end
        applyStimulus(NR'($urandom_range(1, (1 << NR) - 1)), 1'b0, 1'b0, 1'b0);
      end
      awaitGrant(owner);
      roll = $urandom_range(0, 9);
      mode = (roll < 2) ? 2 : ((roll == 2) ? 1 : 0);
      nextReq = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom_range(0, (1 << NR) - 1));
      finishTransaction(owner, mode, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), NR'($urandom_range(0, (1 << NR) - 1)), nextReq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
    $finish;
  end

endmodule
